add_comp_pipe: RTL and testbench
================================

ADD_COMP_PIPE -- requirements
Module: add_comp_pipe

Interface
REQ-001 Parameter W, default 8: operand width; sum and threshold width W+1.
REQ-002 Parameter PV, default 50: threshold reset value; must fit in W+1 bits.
REQ-003 Parameter CW, default 8: match counter width.
REQ-004 One clock; reset is synchronous and active-low; ports clk and rst_n.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 in_valid  in  1  input beat offered.
REQ-008 in_ready  out  1  input beat accepted when in_valid && in_ready.
REQ-009 n1, n2  in  W each  operands.
REQ-010 enable_sum  in  1  per-beat enable; 0 produces a zero result beat.
REQ-011 acc_mode  in  1  0 = pairwise sum, 1 = accumulate.
REQ-012 acc_clr  in  1  clear accumulator.
REQ-013 thr_load, thr_in  in  1, W+1  load new threshold.
REQ-014 out_valid  out  1  result beat present; out_ready  in  1  downstream accept.
REQ-015 sum  out  W+1  result; more, less, match  out  1 each  compare flags.
REQ-016 sat  out  1  sticky accumulator-saturation flag; match_cnt  out  CW  match count.

Function
REQ-017 Output stage SHALL be a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-018 in_ready SHALL equal !out_valid || out_ready (combinational).
REQ-019 EMPTY->FULL on accept; FULL->EMPTY on out_ready with no accept; FULL->FULL on simultaneous pop and accept, loading the new beat.
REQ-020 Latency SHALL be one cycle: beat accepted at edge k appears on outputs after edge k.
REQ-021 While FULL and out_ready=0, sum and all flags SHALL hold stable.
REQ-022 Pairwise: sum = n1 + n2, zero-extended to W+1 bits, no loss.
REQ-023 Accumulate: acc_next = acc + n1 + n2, saturating at 2^(W+1)-1; sum = acc_next; acc updates only on accept.
REQ-024 Saturation SHALL set sat; sat clears only on acc_clr or reset.
REQ-025 acc_clr without accept clears acc to 0; with accept, the beat sums from acc = 0.
REQ-026 Pairwise beats SHALL NOT modify acc.
REQ-027 Flags for an enabled beat: exactly one of match (sum==thr), more (sum>thr), less (sum<thr).
REQ-028 enable_sum=0 on accept: sum=0, all flags 0, acc unchanged, beat still produced.
REQ-029 thr_load updates thr at the edge; a beat accepted at the same edge uses the old thr.
REQ-030 match_cnt SHALL increment once per beat popped (out_valid && out_ready) with match=1, saturating at 2^CW-1.

Reset
REQ-031 rst_n=0 at an edge: FSM EMPTY, out_valid=0, sum=0, more=less=match=0, acc=0, sat=0, thr=PV, match_cnt=0.
REQ-032 Reset mid-operation SHALL discard any held beat without popping or counting it.
REQ-033 in_ready SHALL be 1 during and immediately after reset.

Structure
REQ-034 Package add_comp_pkg SHALL hold the cmp_res_t enum (LESS, MATCH, MORE), the FSM state enum, and the default PV constant.
REQ-035 Sub-module add_comp_core SHALL be purely combinational: operands, acc, mode, enable, thr in; next sum, cmp_res_t, saturation out.

Verification (W=8, PV=50, CW=8)
REQ-036 Pairwise 20+30, out_ready=1 -> next cycle sum=50, match=1; match_cnt=1 after pop.
REQ-037 out_ready=0, beats 10+10 then 90+90 -> first held (sum=20, less=1), in_ready=0; second loads only on out_ready=1 -> sum=180, more=1.
REQ-038 Accumulate 200+200 twice -> sum=400 more=1, then sum=511 sat=1; acc_clr with 1+1 -> sum=2, less=1, sat=0.
REQ-039 thr_load thr_in=100 with accepted 60+40 -> more=1; next 60+40 -> match=1.
REQ-040 enable_sum=0 with 25+25 -> sum=0, all flags 0, match_cnt unchanged.
REQ-041 Hold FULL beat, then rst_n=0 one cycle -> out_valid=0, thr=50, acc=0, match_cnt=0, in_ready=1.

Source files
------------

// File: rtl/add_comp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : add_comp_pkg
//  Description : Shared types and constants for the add/compare pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package add_comp_pkg;

  // Three-way compare result of a sum against the threshold
  typedef enum logic [1:0] {
    LESS  = 2'd0,
    MATCH = 2'd1,
    MORE  = 2'd2
  } cmp_res_t;

  // Output stage occupancy
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  // Threshold value restored at reset
  localparam int c_pv_default = 50;

endpackage : add_comp_pkg
`default_nettype wire

// File: rtl/add_comp_core.sv
`default_nettype none
// ============================================================================
//  Module      : add_comp_core
//  Description : Combinational adder/accumulator step with saturation and a
//                three-way compare against the threshold.
//  Revision    : 1.0 - initial release
// ============================================================================
module add_comp_core
  import add_comp_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] n1,
  input  logic [W-1:0] n2,
  input  logic [W:0]   acc,
  input  logic         acc_mode,
  input  logic         enable,
  input  logic [W:0]   thr,
  output logic [W:0]   sum_next,
  output cmp_res_t     res,
  output logic         sat_hit
);

  // One guard bit above the result width catches accumulator overflow
  localparam logic [W+1:0] c_max = {1'b0, {(W+1){1'b1}}};

  logic [W+1:0] w_base;
  logic [W+1:0] w_total;
  logic         w_over;
  logic [W:0]   w_clamped;

  assign w_base    = acc_mode ? {1'b0, acc} : '0;
  assign w_total   = w_base + {2'b00, n1} + {2'b00, n2};
  assign w_over    = acc_mode && (w_total > c_max);
  assign w_clamped = w_over ? c_max[W:0] : w_total[W:0];

  // Disabled beats produce zero and never report saturation
  always_comb begin
    sum_next = enable ? w_clamped : '0;
    sat_hit  = enable && w_over;
    if (sum_next < thr) begin
      res = LESS;
    end else if (sum_next == thr) begin
      res = MATCH;
    end else begin
      res = MORE;
    end
  end

endmodule : add_comp_core
`default_nettype wire

// File: rtl/add_comp_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : add_comp_pipe
//  Description : One-deep valid/ready pipeline computing a pairwise or
//                accumulated sum, compare flags against a loadable threshold,
//                a sticky saturation flag and a popped-match counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module add_comp_pipe
  import add_comp_pkg::*;
#(
  parameter int W  = 8,
  parameter int PV = c_pv_default,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  n1,
  input  logic [W-1:0]  n2,
  input  logic          enable_sum,
  input  logic          acc_mode,
  input  logic          acc_clr,
  input  logic          thr_load,
  input  logic [W:0]    thr_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W:0]    sum,
  output logic          more,
  output logic          less,
  output logic          match,
  output logic          sat,
  output logic [CW-1:0] match_cnt
);

  localparam logic [W:0]    c_pv      = PV[W:0];
  localparam logic [CW-1:0] c_cnt_max = {CW{1'b1}};

  out_state_t    r_state;
  logic [W:0]    r_sum;
  logic          r_more;
  logic          r_less;
  logic          r_match;
  logic [W:0]    r_acc;
  logic          r_sat;
  logic [W:0]    r_thr;
  logic [CW-1:0] r_cnt;

  logic          w_accept;
  logic          w_pop;
  logic [W:0]    w_acc_base;
  logic [W:0]    w_sum_next;
  cmp_res_t      w_res;
  logic          w_sat_hit;
  logic          w_acc_write;

  assign out_valid   = (r_state == FULL);
  assign in_ready    = !out_valid || out_ready;
  assign w_accept    = in_valid && in_ready;
  assign w_pop       = out_valid && out_ready;
  // A clear in the same cycle as a beat makes that beat start from zero
  assign w_acc_base  = acc_clr ? '0 : r_acc;
  assign w_acc_write = w_accept && enable_sum && acc_mode;

  assign sum       = r_sum;
  assign more      = r_more;
  assign less      = r_less;
  assign match     = r_match;
  assign sat       = r_sat;
  assign match_cnt = r_cnt;

  add_comp_core #(
    .W (W)
  ) u_core (
    .n1       (n1),
    .n2       (n2),
    .acc      (w_acc_base),
    .acc_mode (acc_mode),
    .enable   (enable_sum),
    .thr      (r_thr),
    .sum_next (w_sum_next),
    .res      (w_res),
    .sat_hit  (w_sat_hit)
  );

  // Output-stage FSM: fill on accept, drain on pop, reload on pop+accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else if (w_accept) begin
      r_state <= FULL;
    end else if (w_pop) begin
      r_state <= EMPTY;
    end
  end

  // Result register loads only on accept so a stalled beat holds stable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_more  <= 1'b0;
      r_less  <= 1'b0;
      r_match <= 1'b0;
    end else if (w_accept) begin
      r_sum   <= w_sum_next;
      r_more  <= enable_sum && (w_res == MORE);
      r_less  <= enable_sum && (w_res == LESS);
      r_match <= enable_sum && (w_res == MATCH);
    end
  end

  // Accumulator and sticky saturation: clear first, then apply an accumulate beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else begin
      r_acc <= w_acc_write ? w_sum_next : w_acc_base;
      if (w_acc_write && w_sat_hit) begin
        r_sat <= 1'b1;
      end else if (acc_clr) begin
        r_sat <= 1'b0;
      end
    end
  end

  // Threshold register; a beat accepted on the load edge already used the old value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_thr <= c_pv;
    end else if (thr_load) begin
      r_thr <= thr_in;
    end
  end

  // Count matching beats as they leave, saturating at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_pop && r_match && (r_cnt != c_cnt_max)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule : add_comp_pipe
`default_nettype wire

// File: tb/tb_add_comp_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_add_comp_pipe
//  Description : Self-checking bench for add_comp_pipe: directed vector table
//                followed by randomized traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_add_comp_pipe;

  localparam int W  = 8;
  localparam int PV = 50;
  localparam int CW = 8;
  localparam int SMAX = (1 << (W + 1)) - 1;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  n1;
  logic [W-1:0]  n2;
  logic          enable_sum;
  logic          acc_mode;
  logic          acc_clr;
  logic          thr_load;
  logic [W:0]    thr_in;
  logic          out_valid;
  logic          out_ready;
  logic [W:0]    sum;
  logic          more;
  logic          less;
  logic          match;
  logic          sat;
  logic [CW-1:0] match_cnt;

  int n_checks = 0;
  int n_errors = 0;

  add_comp_pipe #(.W(W), .PV(PV), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .n1         (n1),
    .n2         (n2),
    .enable_sum (enable_sum),
    .acc_mode   (acc_mode),
    .acc_clr    (acc_clr),
    .thr_load   (thr_load),
    .thr_in     (thr_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum        (sum),
    .more       (more),
    .less       (less),
    .match      (match),
    .sat        (sat),
    .match_cnt  (match_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rst_n, iv, ordy, a, b, en, mode, clr, tl, tin;
    int e_ov, e_ir, e_sum, e_more, e_less, e_match, e_sat, e_cnt;
  } vec_t;

  function automatic vec_t mkv(int r, int iv, int ordy, int a, int b, int en,
                               int mode, int clr, int tl, int tin,
                               int ov, int ir, int s, int mo, int le, int ma,
                               int st, int cnt);
    vec_t v;
    v.rst_n = r; v.iv = iv; v.ordy = ordy; v.a = a; v.b = b; v.en = en;
    v.mode = mode; v.clr = clr; v.tl = tl; v.tin = tin;
    v.e_ov = ov; v.e_ir = ir; v.e_sum = s; v.e_more = mo; v.e_less = le;
    v.e_match = ma; v.e_sat = st; v.e_cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic drive(input int r, input int iv, input int ordy, input int a,
                       input int b, input int en, input int mode, input int clr,
                       input int tl, input int tin);
    rst_n      = r[0];
    in_valid   = iv[0];
    out_ready  = ordy[0];
    n1         = a[W-1:0];
    n2         = b[W-1:0];
    enable_sum = en[0];
    acc_mode   = mode[0];
    acc_clr    = clr[0];
    thr_load   = tl[0];
    thr_in     = tin[W:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  int m_ov, m_sum, m_more, m_less, m_match, m_acc, m_sat, m_thr, m_cnt;

  task automatic model_step();
    int ready, accept, pop, base, total, nsat;
    if (!rst_n) begin
      m_ov = 0; m_sum = 0; m_more = 0; m_less = 0; m_match = 0;
      m_acc = 0; m_sat = 0; m_thr = PV; m_cnt = 0;
      return;
    end
    ready  = (!m_ov || out_ready) ? 1 : 0;
    accept = (in_valid && ready) ? 1 : 0;
    pop    = (m_ov && out_ready) ? 1 : 0;
    if (pop && m_match && m_cnt < CMAX) m_cnt++;
    base = acc_clr ? 0 : m_acc;
    nsat = acc_clr ? 0 : m_sat;
    if (accept) begin
      if (enable_sum) begin
        total = acc_mode ? base + int'(n1) + int'(n2) : int'(n1) + int'(n2);
        if (acc_mode && total > SMAX) begin
          total = SMAX;
          nsat  = 1;
        end
        m_acc   = acc_mode ? total : base;
        m_sum   = total;
        m_more  = (total > m_thr) ? 1 : 0;
        m_less  = (total < m_thr) ? 1 : 0;
        m_match = (total == m_thr) ? 1 : 0;
      end else begin
        m_acc = base;
        m_sum = 0; m_more = 0; m_less = 0; m_match = 0;
      end
      m_ov = 1;
    end else begin
      m_acc = base;
      if (pop) m_ov = 0;
    end
    m_sat = nsat;
    if (thr_load) m_thr = int'(thr_in);
  endtask

  vec_t vecs[20];

  initial begin
    // --------------- directed table ---------------
    //              rst iv or  a   b  en md clr tl tin   ov ir sum mo le ma sat cnt
    vecs[0]  = mkv(0, 0, 0,  0,  0, 1, 0, 0, 0, 0,    0, 1,  0, 0, 0, 0, 0, 0);
    vecs[1]  = mkv(1, 1, 1, 20, 30, 1, 0, 0, 0, 0,    1, 1, 50, 0, 0, 1, 0, 0);
    vecs[2]  = mkv(1, 0, 1,  0,  0, 1, 0, 0, 0, 0,    0, 1,  0, 0, 0, 0, 0, 1);
    vecs[3]  = mkv(1, 1, 0, 10, 10, 1, 0, 0, 0, 0,    1, 0, 20, 0, 1, 0, 0, 1);
    vecs[4]  = mkv(1, 1, 0, 90, 90, 1, 0, 0, 0, 0,    1, 0, 20, 0, 1, 0, 0, 1);
    vecs[5]  = mkv(1, 1, 1, 90, 90, 1, 0, 0, 0, 0,    1, 1,180, 1, 0, 0, 0, 1);
    vecs[6]  = mkv(1, 0, 1,  0,  0, 1, 0, 0, 0, 0,    0, 1,  0, 0, 0, 0, 0, 1);
    vecs[7]  = mkv(1, 1, 1,200,200, 1, 1, 0, 0, 0,    1, 1,400, 1, 0, 0, 0, 1);
    vecs[8]  = mkv(1, 1, 1,200,200, 1, 1, 0, 0, 0,    1, 1,511, 1, 0, 0, 1, 1);
    vecs[9]  = mkv(1, 1, 1,  1,  1, 1, 1, 1, 0, 0,    1, 1,  2, 0, 1, 0, 0, 1);
    vecs[10] = mkv(1, 0, 1,  0,  0, 1, 0, 0, 0, 0,    0, 1,  0, 0, 0, 0, 0, 1);
    vecs[11] = mkv(1, 1, 1, 60, 40, 1, 0, 0, 1,100,   1, 1,100, 1, 0, 0, 0, 1);
    vecs[12] = mkv(1, 1, 1, 60, 40, 1, 0, 0, 0, 0,    1, 1,100, 0, 0, 1, 0, 1);
    vecs[13] = mkv(1, 0, 1,  0,  0, 1, 0, 0, 0, 0,    0, 1,  0, 0, 0, 0, 0, 2);
    vecs[14] = mkv(1, 1, 1, 25, 25, 0, 0, 0, 0, 0,    1, 1,  0, 0, 0, 0, 0, 2);
    vecs[15] = mkv(1, 0, 1,  0,  0, 1, 0, 0, 0, 0,    0, 1,  0, 0, 0, 0, 0, 2);
    // acc still 2: pairwise and disabled beats left it alone; thr is 100
    vecs[16] = mkv(1, 1, 1,  0,  0, 1, 1, 0, 0, 0,    1, 1,  2, 0, 1, 0, 0, 2);
    vecs[17] = mkv(1, 1, 0, 50, 50, 1, 0, 0, 0, 0,    1, 0,  2, 0, 1, 0, 0, 2);
    vecs[18] = mkv(0, 0, 0,  0,  0, 1, 0, 0, 0, 0,    0, 1,  0, 0, 0, 0, 0, 0);
    // after reset: acc=0 and thr=50 both visible through this accumulate beat
    vecs[19] = mkv(1, 1, 1, 20, 30, 1, 1, 0, 0, 0,    1, 1, 50, 0, 0, 1, 0, 0);

    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].rst_n, vecs[i].iv, vecs[i].ordy, vecs[i].a, vecs[i].b,
            vecs[i].en, vecs[i].mode, vecs[i].clr, vecs[i].tl, vecs[i].tin);
      tick();
      check($sformatf("v%0d out_valid", i), int'(out_valid), vecs[i].e_ov);
      check($sformatf("v%0d in_ready", i),  int'(in_ready),  vecs[i].e_ir);
      check($sformatf("v%0d sat", i),       int'(sat),       vecs[i].e_sat);
      check($sformatf("v%0d match_cnt", i), int'(match_cnt), vecs[i].e_cnt);
      if (vecs[i].e_ov != 0 || vecs[i].rst_n == 0) begin
        check($sformatf("v%0d sum", i),   int'(sum),   vecs[i].e_sum);
        check($sformatf("v%0d more", i),  int'(more),  vecs[i].e_more);
        check($sformatf("v%0d less", i),  int'(less),  vecs[i].e_less);
        check($sformatf("v%0d match", i), int'(match), vecs[i].e_match);
      end
    end

    // Final pop of the post-reset match beat is counted
    drive(1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    tick();
    check("post-reset pop cnt", int'(match_cnt), 1);
    check("post-reset pop ov", int'(out_valid), 0);

    // --------------- randomized traffic vs model ---------------
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    model_step();
    tick();
    for (int c = 0; c < 3000; c++) begin
      int r, iv, ordy, a, b, en, mode, clr, tl, tin;
      r    = ($urandom_range(0, 199) == 0) ? 0 : 1;
      iv   = ($urandom_range(0, 3) != 0) ? 1 : 0;
      ordy = ($urandom_range(0, 2) != 0) ? 1 : 0;
      a    = $urandom_range(0, 255);
      b    = $urandom_range(0, 255);
      en   = ($urandom_range(0, 7) != 0) ? 1 : 0;
      mode = ($urandom_range(0, 2) == 0) ? 1 : 0;
      clr  = ($urandom_range(0, 9) == 0) ? 1 : 0;
      tl   = ($urandom_range(0, 15) == 0) ? 1 : 0;
      tin  = $urandom_range(0, 511);
      if ($urandom_range(0, 2) == 0 && m_thr <= 510) begin
        // aim a pairwise beat exactly at the threshold
        a    = (m_thr > 255) ? 255 : m_thr;
        b    = m_thr - a;
        mode = 0;
        en   = 1;
      end
      drive(r, iv, ordy, a, b, en, mode, clr, tl, tin);
      model_step();
      tick();
      check("rnd out_valid", int'(out_valid), m_ov);
      check("rnd in_ready",  int'(in_ready),  (!m_ov || ordy != 0) ? 1 : 0);
      check("rnd sat",       int'(sat),       m_sat);
      check("rnd match_cnt", int'(match_cnt), m_cnt);
      if (m_ov != 0) begin
        check("rnd sum",   int'(sum),   m_sum);
        check("rnd more",  int'(more),  m_more);
        check("rnd less",  int'(less),  m_less);
        check("rnd match", int'(match), m_match);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_add_comp_pipe
`default_nettype wire
